// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one cache_and_ram port.
// Holds the memory inputs for MEM_LATENCY cycles, then returns read data with a one-cycle ack.
module cache_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              mode0,
  input  logic              mode1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              grant,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_mode,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_mode_q, mem_mode_d;
  logic              sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_mode_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_mode_q    <= mem_mode_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_mode_d    = mem_mode_q;
    sel           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On contention the requester not served last time wins
          sel           = (req0 && req1) ? ~last_grant_q : req1;
          grant_d       = sel;
          last_grant_d  = sel;
          mem_address_d = sel ? addr1 : addr0;
          mem_data_d    = sel ? wdata1 : wdata0;
          mem_mode_d    = sel ? mode1 : mode0;
          cnt_d         = CNT_LOAD;
          state_d       = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          if (!mem_mode_q) begin
            if (grant_q) rdata1_d = mem_out;
            else         rdata0_d = mem_out;
          end
          ack0_d     = ~grant_q;
          ack1_d     = grant_q;
          mem_mode_d = 1'b0;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = (state_q != S_IDLE);
  assign grant       = grant_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_mode    = mem_mode_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: queued requesters, a fake cache and a
// transaction-level timing model predicting every output cycle by cycle.
module tb_cache_port_arbiter;

  localparam int LAT = 4;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, mode0, mode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, busy, grant, mem_mode;
  logic [31:0] rdata0, rdata1, mem_address, mem_data;
  logic [31:0] mem_out;

  logic        b_req1;
  logic [31:0] b_addr1;
  logic        b_ack0, b_ack1, b_busy, b_grant, b_mem_mode;
  logic [31:0] b_rdata0, b_rdata1, b_mem_address, b_mem_data, b_mem_out;

  always #5 clk = ~clk;

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .grant(grant),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_mode(mem_mode), .mem_out(mem_out)
  );

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(1'b0), .req1(b_req1), .mode0(1'b0), .mode1(1'b0),
    .addr0(32'h0), .addr1(b_addr1), .wdata0(32'h0), .wdata1(32'h0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .busy(b_busy), .grant(b_grant),
    .mem_address(b_mem_address), .mem_data(b_mem_data),
    .mem_mode(b_mem_mode), .mem_out(b_mem_out)
  );

  assign b_mem_out = b_mem_address ^ 32'h5A5A_0F0F;

  // fake cache_and_ram: writes land and reads settle at the falling edge
  logic [31:0] cache [logic [31:0]];
  always @(negedge clk) begin
    if (mem_mode) cache[mem_address] = mem_data;
    mem_out = cache.exists(mem_address) ? cache[mem_address] : 32'h0;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  rq_t         q0[$], q1[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          n, m_start, m_free_at;
  logic        m_valid, m_who, m_last, m_mode;
  logic [31:0] m_addr, m_wdata, e_rd0, e_rd1;
  int          mm_cnt, ack0_cnt;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic model_reset();
    n = 0; m_free_at = 0; m_start = 0;
    m_valid = 1'b0; m_who = 1'b0; m_last = 1'b1; m_mode = 1'b0;
    m_addr = '0; m_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    q0.delete(); q1.delete();
    ref_mem.delete(); cache.delete();
  endtask

  task automatic drive();
    rq_t h0, h1;
    h0 = '{1'b0, 32'h0, 32'h0};
    h1 = '{1'b0, 32'h0, 32'h0};
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    req0 = (q0.size() > 0); mode0 = h0.mode; addr0 = h0.addr; wdata0 = h0.wdata;
    req1 = (q1.size() > 0); mode1 = h1.mode; addr1 = h1.addr; wdata1 = h1.wdata;
  endtask

  task automatic cycle();
    rq_t r;
    logic in_txn, at_ack;
    drive();
    @(posedge clk);
    // a grant can happen only once the previous transaction plus its idle gap has elapsed
    if (n >= m_free_at && (q0.size() > 0 || q1.size() > 0)) begin
      m_who = (q0.size() > 0 && q1.size() > 0) ? ~m_last : (q1.size() > 0);
      m_last = m_who;
      r = m_who ? q1[0] : q0[0];
      m_mode = r.mode; m_addr = r.addr; m_wdata = r.wdata;
      m_start = n; m_valid = 1'b1; m_free_at = n + LAT + 2;
    end
    in_txn = m_valid && n >= m_start && n <= m_start + LAT;
    at_ack = m_valid && n == m_start + LAT;
    if (at_ack) begin
      if (m_mode) ref_mem[m_addr] = m_wdata;
      else if (m_who) e_rd1 = ref_rd(m_addr);
      else e_rd0 = ref_rd(m_addr);
    end
    #1;
    chk("busy", busy, in_txn);
    chk("mem_mode", mem_mode, in_txn && !at_ack && m_mode);
    chk("ack0", ack0, at_ack && !m_who);
    chk("ack1", ack1, at_ack && m_who);
    chk("grant", grant, m_who);
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    if (in_txn) begin
      chk("mem_address", mem_address, m_addr);
      if (m_mode) chk("mem_data", mem_data, m_wdata);
    end
    if (mem_mode) mm_cnt++;
    if (ack0) ack0_cnt++;
    if (ack0 && q0.size() > 0) void'(q0.pop_front());
    if (ack1 && q1.size() > 0) void'(q1.pop_front());
    n++;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 2000;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      chk({tag, "_timeout"}, 1, 0);
      q0.delete(); q1.delete();
    end
    repeat (LAT + 2) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_mem_mode"}, mem_mode, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
  endtask

  initial begin
    int budget;
    rq_t r;
    rst = 1'b1; b_req1 = 1'b0; b_addr1 = '0;
    model_reset();
    drive();
    #3;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // write then read back from requester 0
    mm_cnt = 0; ack0_cnt = 0;
    q0.push_back('{1'b1, 32'd0, 32'd14528});
    q0.push_back('{1'b0, 32'd0, 32'd0});
    drain("t2");
    chk("t2_mode_cycles", mm_cnt, LAT);
    chk("t2_ack0_pulses", ack0_cnt, 2);
    chk("t2_rdata0", rdata0, 32'd14528);

    // reset in the middle of a write
    q0.push_back('{1'b1, 32'h40, 32'hDEAD_BEEF});
    budget = 20;
    while (!mem_mode && budget > 0) begin
      cycle();
      budget--;
    end
    chk("t5_write_started", mem_mode, 1);
    cycle();
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    model_reset();
    drive();
    @(posedge clk);
    #1 chk("t5_no_ack", ack0 | ack1, 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // simultaneous write (req0) and read (req1) right after reset
    q0.push_back('{1'b1, 32'd2816867292, 32'd526421});
    q1.push_back('{1'b0, 32'd2816867292, 32'd0});
    cycle();
    chk("t1_first_grant", grant, 0);
    drain("t3");
    chk("t3_rdata1", rdata1, 32'd526421);

    // both held high with reads: strict alternation
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 32'd1001425, 32'd0});
      q1.push_back('{1'b0, 32'd1001425, 32'd0});
    end
    drain("t4");

    // randomized traffic over a small address set
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(3) == 0) begin
        r.mode = 1'($urandom_range(1));
        r.addr = 32'h100 + 32'($urandom_range(3)) * 4;
        r.wdata = $urandom;
        q0.push_back(r);
      end
      if (q1.size() == 0 && $urandom_range(3) == 0) begin
        r.mode = 1'($urandom_range(1));
        r.addr = 32'h100 + 32'($urandom_range(3)) * 4;
        r.wdata = $urandom;
        q1.push_back(r);
      end
      cycle();
    end
    drain("rand");

    // MEM_LATENCY = 1 instance
    b_req1 = 1'b1; b_addr1 = 32'h0000_1234;
    @(posedge clk);
    #1;
    chk("l1_busy_c1", b_busy, 1);
    chk("l1_ack1_c1", b_ack1, 0);
    @(posedge clk);
    #1;
    chk("l1_busy_c2", b_busy, 1);
    chk("l1_ack1_c2", b_ack1, 1);
    chk("l1_grant", b_grant, 1);
    chk("l1_rdata1", b_rdata1, 32'h0000_1234 ^ 32'h5A5A_0F0F);
    b_req1 = 1'b0;
    @(posedge clk);
    #1;
    chk("l1_busy_c3", b_busy, 0);
    chk("l1_ack1_c3", b_ack1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
